pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and address width.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter FETCH_BYTES, default 4, sequential PC increment.
REQ-004 SHALL have parameter QDEPTH, default 4 (power of two, >=2), maximum outstanding fetches.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: stall in 1 front-end stall; jmp_valid in 1 branch redirect; jmp_pc in ADDR_W branch target; exc_valid in 1 exception redirect; exc_pc in ADDR_W trap vector.
REQ-007 SHALL have ports: req_valid out 1; req_pc out ADDR_W; req_ready in 1 (fetch request handshake to memory).
REQ-008 SHALL have ports: resp_valid in 1 in-order fetch response strobe; inst_valid out 1 response accepted; inst_pc out ADDR_W PC of accepted response; misalign_o out 1 misaligned target flag.

Function
REQ-009 SHALL hold PC register pc; req_pc = pc combinationally.
REQ-010 SHALL track live_cnt (issued, unflushed) and stale_cnt (issued, flushed, response pending); live_cnt+stale_cnt <= QDEPTH always.
REQ-011 SHALL drive req_valid = !stall && !redirect && (live_cnt+stale_cnt < QDEPTH) && !misalign_o, where redirect = jmp_valid || exc_valid.
REQ-012 SHALL, on req_valid && req_ready, push pc into a QDEPTH-entry PC FIFO, increment live_cnt, and set pc <= pc + FETCH_BYTES (modulo 2^ADDR_W; wraps silently).
REQ-013 SHALL, on redirect, load pc with exc_pc if exc_valid else jmp_pc (exception wins), regardless of stall.
REQ-014 SHALL, on redirect, empty the PC FIFO and set stale_cnt <= stale_cnt + live_cnt - (1 if this cycle's response consumed a live entry), live_cnt <= 0.
REQ-015 SHALL, on resp_valid with stale_cnt>0, drop the response (inst_valid=0) and decrement stale_cnt.
REQ-016 SHALL, on resp_valid with stale_cnt==0 and live_cnt>0, assert inst_valid in the same cycle with inst_pc = FIFO head, pop, decrement live_cnt.
REQ-017 SHALL ignore resp_valid when live_cnt+stale_cnt==0 (no count change, inst_valid=0).
REQ-018 SHALL allow push and pop in the same cycle, leaving live_cnt unchanged.
REQ-019 SHALL drive inst_pc = FIFO head whenever inst_valid=0 (don't-care for checking).

Reset
REQ-020 SHALL, on rst, set pc=RESET_VEC, live_cnt=0, stale_cnt=0, FIFO empty, misalign_o=0; rst overrides redirect and handshakes.
REQ-021 SHALL force req_valid=0 and inst_valid=0 during the rst cycle; responses to pre-reset requests are not tracked.

Configuration
REQ-022 SHALL, with PCGEN_ALIGN_CHK_EN defined, set misalign_o=1 on a redirect whose selected target has nonzero bits [1:0], load pc with the target unchanged, and hold misalign_o until the next aligned redirect or reset.
REQ-023 SHALL, without PCGEN_ALIGN_CHK_EN, clear bits [1:0] of the selected redirect target when loading pc and tie misalign_o to 0.

Verification
REQ-024 SHALL test reset-and-stream: rst 1 cycle, req_ready=1, no stall -> req_pc 0x0,0x4,0x8,0xC on 4 consecutive cycles, then req_valid=0 (QDEPTH full) until resp_valid.
REQ-025 SHALL test in-order responses: after 3 issues from 0x0, 3 resp_valid pulses -> inst_pc 0x0,0x4,0x8 with inst_valid each cycle.
REQ-026 SHALL test flush: 3 outstanding, jmp_valid jmp_pc=0x100 -> next req_pc 0x100; next 3 responses dropped; 4th response gives inst_pc 0x100.
REQ-027 SHALL test priority: jmp_valid jmp_pc=0x200 and exc_valid exc_pc=0x80 with stall=1 -> pc=0x80, req_valid=0 that cycle.
REQ-028 SHALL test wrap: RESET_VEC=0xFFFFFFFC, one accepted request -> pc=0x0.
REQ-029 SHALL test alignment: redirect to 0x102 -> with PCGEN_ALIGN_CHK_EN, misalign_o=1 and req_valid=0 until an aligned redirect; without it, req_pc=0x100.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential PC, redirects, outstanding-fetch tracking with in-order response tagging.
// Optional feature macro: PCGEN_ALIGN_CHK_EN (flag misaligned redirect targets instead of force-aligning them).
module pc_gen #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int unsigned       FETCH_BYTES = 4,
  parameter int unsigned       QDEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_pc,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_pc,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_pc,
  input  logic              req_ready,
  input  logic              resp_valid,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              misalign_o
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned PTR_W = $clog2(QDEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  live_q, live_d;
  logic [CNT_W-1:0]  stale_q, stale_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] fifo_q [QDEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] tgt_load;
  logic              tgt_misalign;
  logic [CNT_W-1:0]  occ;
  logic              push;
  logic              pop;
  logic              drop;

  assign redirect = jmp_valid | exc_valid;
  assign target   = exc_valid ? exc_pc : jmp_pc;
  assign occ      = live_q + stale_q;

`ifdef PCGEN_ALIGN_CHK_EN
  assign tgt_load     = target;
  assign tgt_misalign = |target[1:0];
`else
  assign tgt_load     = target & ~ADDR_W'(3);
  assign tgt_misalign = 1'b0;
`endif

  // Responses return in issue order: flushed ones are consumed before live ones.
  assign req_valid  = !rst && !stall && !redirect && (occ < CNT_W'(QDEPTH)) && !misalign_q;
  assign push       = req_valid && req_ready;
  assign drop       = !rst && resp_valid && (stale_q != '0);
  assign pop        = !rst && resp_valid && (stale_q == '0) && (live_q != '0);

  assign req_pc     = pc_q;
  assign inst_valid = pop;
  assign inst_pc    = fifo_q[rd_ptr_q];
  assign misalign_o = misalign_q;

  always_comb begin
    pc_d       = pc_q;
    live_d     = live_q;
    stale_d    = stale_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    misalign_d = misalign_q;
    if (rst) begin
      pc_d       = RESET_VEC;
      live_d     = '0;
      stale_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      misalign_d = 1'b0;
    end else if (redirect) begin
      // Every live fetch becomes stale except one answered this very cycle.
      pc_d       = tgt_load;
      misalign_d = tgt_misalign;
      stale_d    = stale_q + live_q - CNT_W'(pop) - CNT_W'(drop);
      live_d     = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_W'(FETCH_BYTES);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      live_d  = live_q + CNT_W'(push) - CNT_W'(pop);
      stale_d = stale_q - CNT_W'(drop);
    end
  end

  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    live_q     <= live_d;
    stale_q    <= stale_d;
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    misalign_q <= misalign_d;
  end

  // PC storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (default config plus a wrap-around instance).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, jmp_valid, exc_valid, req_ready, resp_valid;
  logic [31:0] jmp_pc, exc_pc;
  logic        req_valid, inst_valid, misalign_o;
  logic [31:0] req_pc, inst_pc;

  logic        w_rst, w_stall, w_jmp_valid, w_exc_valid, w_req_ready, w_resp_valid;
  logic [31:0] w_jmp_pc, w_exc_pc;
  logic        w_req_valid, w_inst_valid, w_misalign_o;
  logic [31:0] w_req_pc, w_inst_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .jmp_valid(jmp_valid), .jmp_pc(jmp_pc),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .resp_valid(resp_valid), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .misalign_o(misalign_o)
  );

  pc_gen #(.RESET_VEC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst), .stall(w_stall),
    .jmp_valid(w_jmp_valid), .jmp_pc(w_jmp_pc),
    .exc_valid(w_exc_valid), .exc_pc(w_exc_pc),
    .req_valid(w_req_valid), .req_pc(w_req_pc), .req_ready(w_req_ready),
    .resp_valid(w_resp_valid), .inst_valid(w_inst_valid), .inst_pc(w_inst_pc),
    .misalign_o(w_misalign_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; jmp_valid = 1'b0; exc_valid = 1'b0;
    jmp_pc = '0; exc_pc = '0; req_ready = 1'b0; resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; req_ready = 1'b1; resp_valid = 1'b1; jmp_valid = 1'b1; jmp_pc = 32'h40;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (req_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 00000000", req_pc); end
    n_cmp++;
    if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", misalign_o); end
    n_cmp++;
    if (req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_idle_req_valid got %b want 1", req_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (req_valid !== 1'b1 || req_pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL stream_%0d got v=%b pc=%h want v=1 pc=%h", i, req_valid, req_pc, 32'(4 * i));
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (req_valid !== 1'b0) begin n_fail++; $display("FAIL stream_full_%0d got v=%b want 0", i, req_valid); end
      tick();
    end
    resp_valid = 1'b1;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || req_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_resp got iv=%b ipc=%h rv=%b want iv=1 ipc=0 rv=0", inst_valid, inst_pc, req_valid);
    end
    tick();
    resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b1 || req_pc !== 32'h10) begin
      n_fail++; $display("FAIL stream_resume got v=%b pc=%h want v=1 pc=00000010", req_valid, req_pc);
    end
  endtask

  task automatic test_inorder();
    do_reset();
    req_ready = 1'b1;
    repeat (3) tick();
    req_ready = 1'b0;
    resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL inorder_%0d got iv=%b pc=%h want iv=1 pc=%h", i, inst_valid, inst_pc, 32'(4 * i));
      end
      tick();
    end
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_empty got iv=%b want 0", inst_valid); end
    tick();
    resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (req_pc !== 32'hC) begin n_fail++; $display("FAIL inorder_pc got %h want 0000000c", req_pc); end
  endtask

  task automatic test_flush();
    do_reset();
    req_ready = 1'b1;
    repeat (3) tick();
    jmp_valid = 1'b1; jmp_pc = 32'h100;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_redirect_rv got %b want 0", req_valid); end
    tick();
    jmp_valid = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b1 || req_pc !== 32'h100) begin
      n_fail++; $display("FAIL flush_target got v=%b pc=%h want v=1 pc=00000100", req_valid, req_pc);
    end
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_%0d got iv=%b want 0", i, inst_valid); end
      tick();
    end
    #1;
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
      n_fail++; $display("FAIL flush_first_live got iv=%b pc=%h want iv=1 pc=00000100", inst_valid, inst_pc);
    end
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    stall = 1'b1; req_ready = 1'b1;
    jmp_valid = 1'b1; jmp_pc = 32'h200;
    exc_valid = 1'b1; exc_pc = 32'h80;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL prio_rv got %b want 0", req_valid); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (req_pc !== 32'h80) begin n_fail++; $display("FAIL prio_pc got %h want 00000080", req_pc); end
    stall = 1'b1;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_rv got %b want 0", req_valid); end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    w_rst = 1'b1; w_stall = 1'b0; w_jmp_valid = 1'b0; w_exc_valid = 1'b0;
    w_jmp_pc = '0; w_exc_pc = '0; w_req_ready = 1'b0; w_resp_valid = 1'b0;
    tick();
    w_rst = 1'b0; w_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (w_req_valid !== 1'b1 || w_req_pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_start got v=%b pc=%h want v=1 pc=fffffffc", w_req_valid, w_req_pc);
    end
    tick();
    w_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (w_req_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 00000000", w_req_pc); end
  endtask

  task automatic test_align();
    do_reset();
    req_ready = 1'b0;
    jmp_valid = 1'b1; jmp_pc = 32'h102;
    tick();
    jmp_valid = 1'b0;
    #1;
`ifdef PCGEN_ALIGN_CHK_EN
    n_cmp++;
    if (misalign_o !== 1'b1 || req_valid !== 1'b0 || req_pc !== 32'h102) begin
      n_fail++; $display("FAIL align_flag got m=%b v=%b pc=%h want m=1 v=0 pc=00000102", misalign_o, req_valid, req_pc);
    end
    tick();
    n_cmp++;
    if (misalign_o !== 1'b1 || req_valid !== 1'b0) begin
      n_fail++; $display("FAIL align_hold got m=%b v=%b want m=1 v=0", misalign_o, req_valid);
    end
    exc_valid = 1'b1; exc_pc = 32'h200;
    tick();
    exc_valid = 1'b0;
    #1;
    n_cmp++;
    if (misalign_o !== 1'b0 || req_valid !== 1'b1 || req_pc !== 32'h200) begin
      n_fail++; $display("FAIL align_clear got m=%b v=%b pc=%h want m=0 v=1 pc=00000200", misalign_o, req_valid, req_pc);
    end
`else
    n_cmp++;
    if (misalign_o !== 1'b0 || req_valid !== 1'b1 || req_pc !== 32'h100) begin
      n_fail++; $display("FAIL align_jmp got m=%b v=%b pc=%h want m=0 v=1 pc=00000100", misalign_o, req_valid, req_pc);
    end
    exc_valid = 1'b1; exc_pc = 32'h303;
    tick();
    exc_valid = 1'b0;
    #1;
    n_cmp++;
    if (misalign_o !== 1'b0 || req_pc !== 32'h300) begin
      n_fail++; $display("FAIL align_exc got m=%b pc=%h want m=0 pc=00000300", misalign_o, req_pc);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_ready = 1'b1;
    tick();
    resp_valid = 1'b1;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || req_valid !== 1'b1 || req_pc !== 32'h4) begin
      n_fail++; $display("FAIL b2b_pushpop got iv=%b ipc=%h rv=%b rpc=%h want 1/0/1/4", inst_valid, inst_pc, req_valid, req_pc);
    end
    tick();
    req_ready = 1'b0;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
      n_fail++; $display("FAIL b2b_second got iv=%b pc=%h want iv=1 pc=00000004", inst_valid, inst_pc);
    end
    tick();
    resp_valid = 1'b0;
    // Two live, then redirect while the older one is answered.
    req_ready = 1'b1;
    repeat (2) tick();
    req_ready = 1'b0;
    jmp_valid = 1'b1; jmp_pc = 32'h40; resp_valid = 1'b1;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin
      n_fail++; $display("FAIL b2b_redir_pop got iv=%b pc=%h want iv=1 pc=00000008", inst_valid, inst_pc);
    end
    tick();
    jmp_valid = 1'b0; resp_valid = 1'b0; req_ready = 1'b1;
    tick();
    req_ready = 1'b0; resp_valid = 1'b1;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got iv=%b want 0", inst_valid); end
    tick();
    #1;
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
      n_fail++; $display("FAIL b2b_live got iv=%b pc=%h want iv=1 pc=00000040", inst_valid, inst_pc);
    end
    tick();
    resp_valid = 1'b0;
  endtask

  initial begin
    idle();
    w_rst = 1'b1; w_stall = 1'b0; w_jmp_valid = 1'b0; w_exc_valid = 1'b0;
    w_jmp_pc = '0; w_exc_pc = '0; w_req_ready = 1'b0; w_resp_valid = 1'b0;
    tick();
    test_reset();
    test_stream();
    test_inorder();
    test_flush();
    test_priority();
    test_wrap();
    test_align();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
